// File: rtl/instr_fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ifetch_pkg
// Purpose  : Shared definitions for the instruction fetch unit: FSM state
//            encodings, the NOOP encoding and default bus widths.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package ifetch_pkg;

  localparam int IFU_ADDR_W = 7;
  localparam int IFU_DATA_W = 16;

  localparam logic [15:0] NOOP_INSTR = 16'h0000;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] READ    = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] DONE    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = IDLE,
    ST_READ    = READ,
    ST_CAPTURE = CAPTURE,
    ST_DONE    = DONE
  } ifu_state_t;

endpackage
`default_nettype wire

// File: rtl/instr_fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit_if
// Purpose  : Bundle of control, memory and status signals between the fetch
//            unit (slave) and the control FSM / instruction memory (master).
// Ports    : pc_clr, fetch_req, pc_inc, imem_rdata   (master -> slave)
//            imem_addr, imem_rd, instruction, pc,
//            busy, fetch_done, pc_wrapped            (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface instr_fetch_unit_if
  import ifetch_pkg::*;
#(
  parameter int ADDR_W = IFU_ADDR_W,
  parameter int DATA_W = IFU_DATA_W
) ();

  logic              pc_clr;
  logic              fetch_req;
  logic              pc_inc;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_rd;
  logic [DATA_W-1:0] imem_rdata;
  logic [DATA_W-1:0] instruction;
  logic [ADDR_W-1:0] pc;
  logic              busy;
  logic              fetch_done;
  logic              pc_wrapped;

  modport master (
    output pc_clr, fetch_req, pc_inc, imem_rdata,
    input  imem_addr, imem_rd, instruction, pc, busy, fetch_done, pc_wrapped
  );

  modport slave (
    input  pc_clr, fetch_req, pc_inc, imem_rdata,
    output imem_addr, imem_rd, instruction, pc, busy, fetch_done, pc_wrapped
  );

endinterface
`default_nettype wire

// File: rtl/instr_fetch_unit_pc_counter.sv
`default_nettype none
// ============================================================================
// Module   : pc_counter
// Purpose  : Program counter register with increment, clear to RESET_PC and
//            a sticky wrap flag raised when the PC rolls over from all-ones.
// Ports    : clock, reset    - clock, synchronous active-high reset
//            clr_i           - clear PC and wrap flag (priority over inc_i)
//            inc_i           - advance PC by one (modulo 2^ADDR_W)
//            pc_o            - current PC
//            wrapped_o       - sticky wrap indication
// Revision : 1.0 - initial release
// ============================================================================
module pc_counter
  import ifetch_pkg::*;
#(
  parameter int ADDR_W   = IFU_ADDR_W,
  parameter int RESET_PC = 0
) (
  input  wire logic              clock,
  input  wire logic              reset,
  input  wire logic              clr_i,
  input  wire logic              inc_i,
  output logic      [ADDR_W-1:0] pc_o,
  output logic                   wrapped_o
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              wrapped_q, wrapped_d;

  always_comb begin
    pc_d      = pc_q;
    wrapped_d = wrapped_q;
    if (clr_i) begin
      pc_d      = ADDR_W'(RESET_PC);
      wrapped_d = 1'b0;
    end else if (inc_i) begin
      pc_d = pc_q + ADDR_W'(1);
      if (&pc_q) begin
        wrapped_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q      <= ADDR_W'(RESET_PC);
      wrapped_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      wrapped_q <= wrapped_d;
    end
  end

  assign pc_o      = pc_q;
  assign wrapped_o = wrapped_q;

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch front end. Holds PC and IR, reads instruction memory
//            through a 1-cycle-latency synchronous port and reports each
//            IR update with a one-cycle fetch_done pulse.
// Ports    : clock, reset    - clock, synchronous active-high reset
//            bus (slave)     - control, memory and status bundle
// Options  : FETCH_PREFETCH_EN - one-entry prefetch buffer; an idle unit
//            reads mem[pc] ahead so the next fetch completes in one cycle.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int ADDR_W   = IFU_ADDR_W,
  parameter int DATA_W   = IFU_DATA_W,
  parameter int RESET_PC = 0
) (
  input wire logic          clock,
  input wire logic          reset,
  instr_fetch_unit_if.slave bus
);

  ifu_state_t        state_q, state_d;
  logic              inc_q, inc_d;
  logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
  logic              imem_rd_q, imem_rd_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              fetch_done_q, fetch_done_d;
  logic              pc_inc_w;
  logic [ADDR_W-1:0] pc_w;
  logic              wrapped_w;

  pc_counter #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) u_pc_counter (
    .clock     (clock),
    .reset     (reset),
    .clr_i     (bus.pc_clr),
    .inc_i     (pc_inc_w),
    .pc_o      (pc_w),
    .wrapped_o (wrapped_w)
  );

`ifdef FETCH_PREFETCH_EN
  logic [DATA_W-1:0] pbuf_data_q, pbuf_data_d;
  logic [ADDR_W-1:0] pbuf_addr_q, pbuf_addr_d;
  logic              pbuf_valid_q, pbuf_valid_d;
  logic              pf_active_q, pf_active_d;   // current READ/CAPTURE fills the buffer
  logic              pend_q, pend_d;             // request parked during a prefetch
  logic              pend_inc_q, pend_inc_d;
  logic              arm_q, arm_d;               // a fetch just completed; prefetch allowed
  logic              req_any_w, inc_any_w, pf_hit_w;

  assign req_any_w = bus.fetch_req | pend_q;
  assign inc_any_w = pend_q ? pend_inc_q : bus.pc_inc;
  // The buffer is only usable for the word the PC currently points at.
  assign pf_hit_w  = pbuf_valid_q && (pbuf_addr_q == pc_w);
`endif

  always_comb begin
    state_d      = state_q;
    inc_d        = inc_q;
    imem_addr_d  = imem_addr_q;
    imem_rd_d    = 1'b0;
    instr_d      = instr_q;
    fetch_done_d = 1'b0;
    pc_inc_w     = 1'b0;
`ifdef FETCH_PREFETCH_EN
    pbuf_data_d  = pbuf_data_q;
    pbuf_addr_d  = pbuf_addr_q;
    pbuf_valid_d = pbuf_valid_q;
    pf_active_d  = pf_active_q;
    pend_d       = pend_q;
    pend_inc_d   = pend_inc_q;
    arm_d        = arm_q;
`endif

    if (bus.pc_clr) begin
      // Clear beats everything, including a same-cycle fetch_req; any
      // outstanding read data is simply never captured.
      state_d = ST_IDLE;
      inc_d   = 1'b0;
      instr_d = DATA_W'(NOOP_INSTR);
`ifdef FETCH_PREFETCH_EN
      pbuf_valid_d = 1'b0;
      pf_active_d  = 1'b0;
      pend_d       = 1'b0;
      arm_d        = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef FETCH_PREFETCH_EN
          if (req_any_w) begin
            pend_d = 1'b0;
            if (pf_hit_w) begin
              instr_d      = pbuf_data_q;
              pc_inc_w     = inc_any_w;
              fetch_done_d = 1'b1;
              arm_d        = 1'b1;
            end else begin
              inc_d       = inc_any_w;
              imem_addr_d = pc_w;
              imem_rd_d   = 1'b1;
              state_d     = ST_READ;
              arm_d       = 1'b0;
            end
          end else if (arm_q) begin
            arm_d = 1'b0;
            if (!pf_hit_w) begin
              imem_addr_d = pc_w;
              imem_rd_d   = 1'b1;
              pf_active_d = 1'b1;
              state_d     = ST_READ;
            end
          end
`else
          if (bus.fetch_req) begin
            inc_d       = bus.pc_inc;
            imem_addr_d = pc_w;
            imem_rd_d   = 1'b1;
            state_d     = ST_READ;
          end
`endif
        end

        ST_READ: begin
          state_d = ST_CAPTURE;
`ifdef FETCH_PREFETCH_EN
          if (pf_active_q && bus.fetch_req && !pend_q) begin
            pend_d     = 1'b1;
            pend_inc_d = bus.pc_inc;
          end
`endif
        end

        ST_CAPTURE: begin
`ifdef FETCH_PREFETCH_EN
          if (pf_active_q) begin
            pbuf_data_d  = bus.imem_rdata;
            pbuf_addr_d  = imem_addr_q;
            pbuf_valid_d = 1'b1;
            pf_active_d  = 1'b0;
            state_d      = ST_IDLE;
            if (bus.fetch_req && !pend_q) begin
              pend_d     = 1'b1;
              pend_inc_d = bus.pc_inc;
            end
          end else
`endif
          begin
            instr_d      = bus.imem_rdata;
            pc_inc_w     = inc_q;
            fetch_done_d = 1'b1;
            state_d      = ST_DONE;
          end
        end

        ST_DONE: begin
          state_d = ST_IDLE;
`ifdef FETCH_PREFETCH_EN
          arm_d = 1'b1;
`endif
          // Sampling here lets fetches run back-to-back every 3 cycles.
          if (bus.fetch_req) begin
            inc_d       = bus.pc_inc;
            imem_addr_d = pc_w;
            imem_rd_d   = 1'b1;
            state_d     = ST_READ;
`ifdef FETCH_PREFETCH_EN
            arm_d = 1'b0;
`endif
          end
        end

        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      inc_q        <= 1'b0;
      imem_addr_q  <= '0;
      imem_rd_q    <= 1'b0;
      instr_q      <= DATA_W'(NOOP_INSTR);
      fetch_done_q <= 1'b0;
`ifdef FETCH_PREFETCH_EN
      pbuf_data_q  <= '0;
      pbuf_addr_q  <= '0;
      pbuf_valid_q <= 1'b0;
      pf_active_q  <= 1'b0;
      pend_q       <= 1'b0;
      pend_inc_q   <= 1'b0;
      arm_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      inc_q        <= inc_d;
      imem_addr_q  <= imem_addr_d;
      imem_rd_q    <= imem_rd_d;
      instr_q      <= instr_d;
      fetch_done_q <= fetch_done_d;
`ifdef FETCH_PREFETCH_EN
      pbuf_data_q  <= pbuf_data_d;
      pbuf_addr_q  <= pbuf_addr_d;
      pbuf_valid_q <= pbuf_valid_d;
      pf_active_q  <= pf_active_d;
      pend_q       <= pend_d;
      pend_inc_q   <= pend_inc_d;
      arm_q        <= arm_d;
`endif
    end
  end

  assign bus.imem_addr   = imem_addr_q;
  assign bus.imem_rd     = imem_rd_q;
  assign bus.instruction = instr_q;
  assign bus.pc          = pc_w;
  assign bus.fetch_done  = fetch_done_q;
  assign bus.pc_wrapped  = wrapped_w;
`ifdef FETCH_PREFETCH_EN
  // Background prefetches stay invisible to the control FSM.
  assign bus.busy = ((state_q != ST_IDLE) && !pf_active_q) || pend_q;
`else
  assign bus.busy = (state_q != ST_IDLE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Self-checking bench for instr_fetch_unit with a behavioural
//            1-cycle-latency instruction memory and an expectation queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
  import ifetch_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  instr_fetch_unit_if bus ();

  instr_fetch_unit dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  logic [15:0] mem [128];
  logic [15:0] rdata_q = 16'h0;
  always @(posedge clock) if (bus.imem_rd) rdata_q <= mem[bus.imem_addr];
  assign bus.imem_rdata = rdata_q;

  typedef struct packed {
    logic [15:0] instr;
    logic [6:0]  pc;
  } exp_t;
  exp_t sb [$];

  typedef struct packed {
    logic        inc;
    logic [15:0] word;
    logic [6:0]  exp_pc;
  } vec_t;
  vec_t vecs [5];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_clr();
    bus.pc_clr = 1'b1;
    tick();
    bus.pc_clr = 1'b0;
  endtask

  // One request; the expectation is queued at issue and retired on fetch_done.
  task automatic do_fetch(input logic inc, input logic [15:0] exp_i, input logic [6:0] exp_pc);
    exp_t e;
    int   n;
    e.instr = exp_i;
    e.pc    = exp_pc;
    sb.push_back(e);
    bus.fetch_req = 1'b1;
    bus.pc_inc    = inc;
    tick();
    bus.fetch_req = 1'b0;
    bus.pc_inc    = 1'b0;
    n = 1;
    while (!bus.fetch_done && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_done_seen", 32'(bus.fetch_done), 32'd1);
    e = sb.pop_front();
    chk("fetch_instr", 32'(bus.instruction), 32'(e.instr));
    chk("fetch_pc", 32'(bus.pc), 32'(e.pc));
`ifndef FETCH_PREFETCH_EN
    chk("fetch_latency", 32'(n), 32'd3);
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   ndone, last, seen;
    logic [6:0] cur_pc;

    vecs[0] = '{inc: 1'b0, word: 16'hA003, exp_pc: 7'd3};
    vecs[1] = '{inc: 1'b1, word: 16'hA003, exp_pc: 7'd4};
    vecs[2] = '{inc: 1'b1, word: 16'hB004, exp_pc: 7'd5};
    vecs[3] = '{inc: 1'b0, word: 16'hC005, exp_pc: 7'd5};
    vecs[4] = '{inc: 1'b1, word: 16'hC005, exp_pc: 7'd6};

    for (int i = 0; i < 128; i++) mem[i] = 16'h0;
    reset         = 1'b1;
    bus.pc_clr    = 1'b0;
    bus.fetch_req = 1'b0;
    bus.pc_inc    = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    chk("rst_pc", 32'(bus.pc), 32'd0);
    chk("rst_instr", 32'(bus.instruction), 32'(NOOP_INSTR));
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.fetch_done), 32'd0);
    chk("rst_wrapped", 32'(bus.pc_wrapped), 32'd0);
    chk("rst_rd", 32'(bus.imem_rd), 32'd0);
    chk("rst_addr", 32'(bus.imem_addr), 32'd0);

    // First fetch: exact cycle-by-cycle timing.
    mem[0] = 16'h2A13;
    bus.fetch_req = 1'b1;
    bus.pc_inc    = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.pc_inc    = 1'b0;
    chk("t1_rd_c1", 32'(bus.imem_rd), 32'd1);
    chk("t1_busy_c1", 32'(bus.busy), 32'd1);
    chk("t1_done_c1", 32'(bus.fetch_done), 32'd0);
    tick();
    chk("t1_rd_c2", 32'(bus.imem_rd), 32'd0);
    chk("t1_done_c2", 32'(bus.fetch_done), 32'd0);
    chk("t1_instr_c2", 32'(bus.instruction), 32'd0);
    tick();
    chk("t1_done_c3", 32'(bus.fetch_done), 32'd1);
    chk("t1_instr_c3", 32'(bus.instruction), 32'h2A13);
    chk("t1_pc_c3", 32'(bus.pc), 32'd1);
    tick();
    chk("t1_done_c4", 32'(bus.fetch_done), 32'd0);
    pulse_clr();
    chk("t1_clr_pc", 32'(bus.pc), 32'd0);
    chk("t1_clr_instr", 32'(bus.instruction), 32'd0);

    // Three back-to-back fetches with fetch_req held high.
    mem[0] = 16'h0000;
    mem[1] = 16'h3123;
    mem[2] = 16'h5000;
    sb.push_back('{instr: 16'h0000, pc: 7'd1});
    sb.push_back('{instr: 16'h3123, pc: 7'd2});
    sb.push_back('{instr: 16'h5000, pc: 7'd3});
    bus.fetch_req = 1'b1;
    bus.pc_inc    = 1'b1;
    ndone = 0;
    last  = 0;
    for (int t = 1; t <= 30 && ndone < 3; t++) begin
      tick();
      if (bus.fetch_done && sb.size() > 0) begin
        e = sb.pop_front();
        chk("b2b_instr", 32'(bus.instruction), 32'(e.instr));
        chk("b2b_pc", 32'(bus.pc), 32'(e.pc));
        if (ndone > 0) chk("b2b_spacing", 32'(t - last), 32'd3);
        last = t;
        ndone++;
        if (ndone == 3) begin
          bus.fetch_req = 1'b0;
          bus.pc_inc    = 1'b0;
        end
      end
    end
    bus.fetch_req = 1'b0;
    bus.pc_inc    = 1'b0;
    chk("b2b_count", 32'(ndone), 32'd3);
    chk("b2b_final_pc", 32'(bus.pc), 32'd3);
    sb.delete();

    // Table of fetches mixing pc_inc values.
    cur_pc = 7'd3;
    for (int i = 0; i < 5; i++) begin
      mem[cur_pc] = vecs[i].word;
      do_fetch(vecs[i].inc, vecs[i].word, vecs[i].exp_pc);
      cur_pc = vecs[i].exp_pc;
    end

    // pc_clr in the READ cycle aborts the fetch.
    tick();
    bus.fetch_req = 1'b1;
    bus.pc_inc    = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.pc_inc    = 1'b0;
    chk("clr_read_rd", 32'(bus.imem_rd), 32'd1);
    pulse_clr();
    chk("clr_busy", 32'(bus.busy), 32'd0);
    chk("clr_pc", 32'(bus.pc), 32'd0);
    chk("clr_instr", 32'(bus.instruction), 32'd0);
    chk("clr_rd", 32'(bus.imem_rd), 32'd0);
    seen = 0;
    repeat (4) begin
      if (bus.fetch_done) seen = 1;
      tick();
    end
    chk("clr_no_done", 32'(seen), 32'd0);
    chk("clr_instr_hold", 32'(bus.instruction), 32'd0);

    // Walk the PC to 127, then wrap.
    for (int i = 0; i < 128; i++) mem[i] = 16'h4000 | 16'(i);
    for (int i = 0; i < 127; i++) do_fetch(1'b1, 16'h4000 | 16'(i), 7'(i + 1));
    chk("wrap_pre_pc", 32'(bus.pc), 32'd127);
    chk("wrap_pre_flag", 32'(bus.pc_wrapped), 32'd0);
    do_fetch(1'b1, 16'h407F, 7'd0);
    chk("wrap_flag", 32'(bus.pc_wrapped), 32'd1);
    tick();
    chk("wrap_sticky", 32'(bus.pc_wrapped), 32'd1);
    pulse_clr();
    chk("wrap_clr_flag", 32'(bus.pc_wrapped), 32'd0);
    chk("wrap_clr_pc", 32'(bus.pc), 32'd0);

`ifdef FETCH_PREFETCH_EN
    // After a fetch, idle time lets the buffer fill; the next fetch is 1 cycle.
    mem[0] = 16'h1234;
    mem[1] = 16'h5678;
    do_fetch(1'b1, 16'h1234, 7'd1);
    seen = 0;
    repeat (4) begin
      tick();
      if (bus.busy) seen = 1;
    end
    chk("pf_busy_low", 32'(seen), 32'd0);
    bus.fetch_req = 1'b1;
    bus.pc_inc    = 1'b1;
    tick();
    bus.fetch_req = 1'b0;
    bus.pc_inc    = 1'b0;
    chk("pf_done", 32'(bus.fetch_done), 32'd1);
    chk("pf_instr", 32'(bus.instruction), 32'h5678);
    chk("pf_pc", 32'(bus.pc), 32'd2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
